// File: rtl/limb_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// limb_serial_addsub_if
// Request/response bundle for the limb-serial adder/subtractor.
//   start     : request; only sampled while the engine is idle
//   subtract  : 0 = A+B, 1 = A-B; captured with start
//   in_a/in_b : operands; captured with start
//   in_m      : modulus; captured with start, used only when MODADD_EN is defined
//   result    : WIDTH+1 bits; bit WIDTH is carry (add) or borrow (sub)
//   busy      : operation in flight
//   done      : one-cycle completion pulse; result valid from this cycle
// master = requester, slave = the arithmetic engine.
// ---------------------------------------------------------------------------
interface limb_serial_addsub_if #(
   parameter int WIDTH = 384
);
   logic             start;
   logic             subtract;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_m;
   logic [WIDTH:0]   result;
   logic             busy;
   logic             done;

   modport master (
      output start, subtract, in_a, in_b, in_m,
      input  result, busy, done
   );

   modport slave (
      input  start, subtract, in_a, in_b, in_m,
      output result, busy, done
   );
endinterface

// File: rtl/limb_serial_addsub.sv
// ---------------------------------------------------------------------------
// limb_serial_addsub
// WIDTH-bit add/subtract processed one LIMB-bit slice per clock through a
// single narrow carry chain. Subtraction is A + ~B + 1 (carry-in of 1).
// Optional modular correction is compiled in with the macro MODADD_EN:
// after the raw pass, a second limb-serial pass computes U = T-M (add) or
// U = T+M (sub) and the final result picks T or U.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; aborts any operation in flight
//   bus   : limb_serial_addsub_if.slave (start/subtract/in_a/in_b/in_m in,
//           result/busy/done out)
//
// Latency: done rises NLIMB+1 cycles after the accepting edge
// (2*NLIMB+1 when MODADD_EN is defined).
// ---------------------------------------------------------------------------
module limb_serial_addsub #(
   parameter int WIDTH = 384,
   parameter int LIMB  = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   limb_serial_addsub_if.slave  bus
);

   localparam int NLIMB = WIDTH / LIMB;
   localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_CORR,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   // Operand shift registers: the current limb always sits at the bottom.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sub_reg;
   logic             carry_reg;
   logic [IDX_W-1:0] idx_reg;
   // Raw sum/difference T; limbs are shifted in from the top.
   logic [WIDTH-1:0] t_reg;
   logic             t_flag_reg;
   logic [WIDTH:0]   result_reg;
   logic             busy_reg;
   logic             done_reg;

`ifdef MODADD_EN
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] u_reg;
`else
   // Modulus is not needed in the plain build.
   logic             unused_m;
   assign unused_m = ^bus.in_m;
`endif

   logic last_limb;
   assign last_limb = (idx_reg == LAST_IDX);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               state_next = S_ADD;
            end
         end
         S_ADD: begin
            if (last_limb) begin
`ifdef MODADD_EN
               state_next = S_CORR;
`else
               state_next = S_DONE;
`endif
            end
         end
         S_CORR: begin
            if (last_limb) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shared limb adder. During ADD it sees A_i and B_i; during CORR it
   // sees T_i and M_i. The second operand is inverted for A-B and for
   // T-M (i.e. when exactly one of subtract / correction is active),
   // which is why the correction pass starts with carry = ~subtract.
   // ------------------------------------------------------------------
   logic             in_corr;
   logic             invert_y;
   logic [LIMB-1:0]  op_x;
   logic [LIMB-1:0]  op_y_raw;
   logic [LIMB-1:0]  op_y;
   logic [LIMB:0]    limb_sum;
   logic [WIDTH+LIMB-1:0] t_shift_in;

   always_comb begin
      in_corr  = (state_reg == S_CORR);
      op_x     = a_reg[LIMB-1:0];
      op_y_raw = b_reg[LIMB-1:0];
`ifdef MODADD_EN
      if (in_corr) begin
         op_x     = t_reg[LIMB-1:0];
         op_y_raw = m_reg[LIMB-1:0];
      end
`endif
      invert_y   = sub_reg ^ in_corr;
      op_y       = invert_y ? ~op_y_raw : op_y_raw;
      limb_sum   = {1'b0, op_x} + {1'b0, op_y} + {{LIMB{1'b0}}, carry_reg};
      t_shift_in = {limb_sum[LIMB-1:0], t_reg};
   end

`ifdef MODADD_EN
   // During CORR, T is rotated so that it returns to its original
   // alignment after NLIMB cycles and is still available for selection.
   logic [WIDTH+LIMB-1:0] t_rotate;
   logic [WIDTH+LIMB-1:0] u_shift_in;
   logic                  use_u;

   always_comb begin
      t_rotate   = {t_reg[LIMB-1:0], t_reg};
      u_shift_in = {limb_sum[LIMB-1:0], u_reg};
      // carry_reg holds the final carry of the correction pass here:
      // for add, carry=1 means T-M did not borrow, i.e. T >= M.
      if (sub_reg) begin
         use_u = t_flag_reg;
      end else begin
         use_u = t_flag_reg | carry_reg;
      end
   end
`endif

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         sub_reg    <= 1'b0;
         carry_reg  <= 1'b0;
         idx_reg    <= '0;
         t_reg      <= '0;
         t_flag_reg <= 1'b0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
`ifdef MODADD_EN
         m_reg      <= '0;
         u_reg      <= '0;
`endif
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.start) begin
                  a_reg     <= bus.in_a;
                  b_reg     <= bus.in_b;
                  sub_reg   <= bus.subtract;
                  carry_reg <= bus.subtract;
                  idx_reg   <= '0;
                  busy_reg  <= 1'b1;
`ifdef MODADD_EN
                  m_reg     <= bus.in_m;
`endif
               end
            end
            S_ADD: begin
               a_reg     <= a_reg >> LIMB;
               b_reg     <= b_reg >> LIMB;
               t_reg     <= t_shift_in[WIDTH+LIMB-1:LIMB];
               carry_reg <= limb_sum[LIMB];
               if (last_limb) begin
                  idx_reg    <= '0;
                  // XOR with subtract turns the carry-out into a borrow.
                  t_flag_reg <= limb_sum[LIMB] ^ sub_reg;
`ifdef MODADD_EN
                  carry_reg  <= ~sub_reg;
`endif
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
`ifdef MODADD_EN
            S_CORR: begin
               t_reg     <= t_rotate[WIDTH+LIMB-1:LIMB];
               m_reg     <= m_reg >> LIMB;
               u_reg     <= u_shift_in[WIDTH+LIMB-1:LIMB];
               carry_reg <= limb_sum[LIMB];
               if (last_limb) begin
                  idx_reg <= '0;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
`endif
            S_DONE: begin
`ifdef MODADD_EN
               result_reg <= {1'b0, (use_u ? u_reg : t_reg)};
`else
               result_reg <= {t_flag_reg, t_reg};
`endif
               done_reg   <= 1'b1;
               busy_reg   <= 1'b0;
            end
            default: begin
               done_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.result = result_reg;
   assign bus.busy   = busy_reg;
   assign bus.done   = done_reg;

endmodule

// File: tb/tb_limb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_limb_serial_addsub
// Directed, table-driven bench for limb_serial_addsub (default parameters).
// Vector table covers raw add/sub (or modular add/sub when MODADD_EN is
// defined); hand-written sequences cover back-to-back starts, operand
// interference, and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_limb_serial_addsub;

   localparam int WIDTH = 384;
   localparam int LIMB  = 64;
   localparam int NLIMB = WIDTH / LIMB;
`ifdef MODADD_EN
   localparam int LAT = 2 * NLIMB + 1;
`else
   localparam int LAT = NLIMB + 1;
`endif

   localparam logic [WIDTH-1:0] P256 =
      {128'h0, 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   typedef struct {
      logic             sub;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH:0]   exp;
   } vec_t;

`ifdef MODADD_EN
   localparam int NV = 5;
`else
   localparam int NV = 8;
`endif

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   limb_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

   limb_serial_addsub #(
      .WIDTH (WIDTH),
      .LIMB  (LIMB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH:0] got,
                        input logic [WIDTH:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // One complete operation; lat = cycles from accepting edge to done,
   // or -1 if done never came within the budget.
   task automatic run_op(input logic sub, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m,
                         output logic [WIDTH:0] res, output int lat);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.subtract = sub;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_m     = m;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_after_accept", {{WIDTH{1'b0}}, bus.busy}, {{WIDTH{1'b0}}, 1'b1});
      lat = -1;
      res = '0;
      for (int c = 1; c <= 4 * LAT + 10; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = c;
            res = bus.result;
            check("busy_at_done", {{WIDTH{1'b0}}, bus.busy}, '0);
            break;
         end
      end
   endtask

   vec_t vecs [NV];

   initial begin
      logic [WIDTH:0] res;
      int             lat;
      int             done_cnt;
      int             done_at [2];
      logic [WIDTH:0] done_res [2];

      tests = 0;
      fails = 0;

`ifdef MODADD_EN
      vecs[0] = '{1'b0, P256 - 1, 2, 1};
      vecs[1] = '{1'b1, 1, 2, {1'b0, P256 - 1}};
      vecs[2] = '{1'b0, 3, 4, 7};
      vecs[3] = '{1'b1, 7, 5, 2};
      vecs[4] = '{1'b0, P256 - 1, 1, 0};
`else
      vecs[0] = '{1'b0, ONES, 1, {1'b1, {WIDTH{1'b0}}}};
      vecs[1] = '{1'b1, 5, 7, {1'b1, ONES - 1}};
      vecs[2] = '{1'b1, 7, 5, 2};
      vecs[3] = '{1'b0, {256'h0, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF}, 1,
                  {1'b0, 256'h0, 128'h2_0000_0000_0000_0000}};
      vecs[4] = '{1'b1, 384'h1234_5678, 0, 385'h1234_5678};
      vecs[5] = '{1'b1, 0, 1, {1'b1, ONES}};
      vecs[6] = '{1'b1, 384'hABCD, 384'hABCD, 0};
      vecs[7] = '{1'b0, {64'h0, {320{1'b1}}}, {64'h0, {320{1'b1}}},
                  {1'b0, 63'h0, {320{1'b1}}, 1'b0}};
`endif

      bus.start    = 1'b0;
      bus.subtract = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_m     = '0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", bus.result, '0);
      check("reset_busy", {{WIDTH{1'b0}}, bus.busy}, '0);
      check("reset_done", {{WIDTH{1'b0}}, bus.done}, '0);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].sub, vecs[i].a, vecs[i].b, P256, res, lat);
         $display("[TB] vec %0d sub=%0b lat=%0d result=%0h", i, vecs[i].sub, lat, res);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), (WIDTH+1)'(lat), (WIDTH+1)'(LAT));
      end

      // ---------------- back-to-back with start held high ----------------
      // First op is 3+4; in_a changes to 10 mid-operation, so the first
      // result must stay 7 and the second accepted op computes 10+4=14.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.subtract = 1'b0;
      bus.in_a     = 3;
      bus.in_b     = 4;
      bus.in_m     = P256;
      done_cnt     = 0;
      done_at[0]   = -1;
      done_at[1]   = -1;
      done_res[0]  = '0;
      done_res[1]  = '0;
      for (int c = 0; c <= 2 * LAT + 6; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            if (done_cnt < 2) begin
               done_at[done_cnt]  = c;
               done_res[done_cnt] = bus.result;
            end
            done_cnt++;
         end
         if (c == 3) bus.in_a = 10;
         if (c == LAT + 1) bus.start = 1'b0;
      end
      $display("[TB] b2b dones=%0d at %0d,%0d results %0h,%0h",
               done_cnt, done_at[0], done_at[1], done_res[0], done_res[1]);
      check("b2b_done_count", (WIDTH+1)'(done_cnt), 2);
      check("b2b_first_time", (WIDTH+1)'(done_at[0]), (WIDTH+1)'(LAT));
      check("b2b_spacing", (WIDTH+1)'(done_at[1] - done_at[0]), (WIDTH+1)'(LAT + 1));
      check("b2b_first_result", done_res[0], 7);
      check("b2b_second_result", done_res[1], 14);

      // ---------------- reset in the middle of an add ----------------
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_a  = 20;
      bus.in_b  = 22;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_done", {{WIDTH{1'b0}}, bus.done}, '0);
      check("abort_result", bus.result, '0);
      check("abort_busy", {{WIDTH{1'b0}}, bus.busy}, '0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 2 * LAT; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_cnt++;
      end
      $display("[TB] abort dones_after_reset=%0d", done_cnt);
      check("abort_no_done", (WIDTH+1)'(done_cnt), 0);

      run_op(1'b0, 20, 22, P256, res, lat);
      $display("[TB] post_abort lat=%0d result=%0h", lat, res);
      check("post_abort_result", res, 42);
      check("post_abort_latency", (WIDTH+1)'(lat), (WIDTH+1)'(LAT));

      // result holds until the next completion, even across a new start
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_a  = 1;
      bus.in_b  = 1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] hold result=%0h", bus.result);
      check("result_held", bus.result, 42);
      repeat (2 * LAT) @(posedge clk);
      #1;
      check("result_after_hold", bus.result, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/limb_serial_addsub.md
Name: limb_serial_addsub

Overview:
- Parametrised successor to the single-shot 384-bit adder/subtractor in the ECDSA datapath.
- Processes WIDTH-bit operands one LIMB-bit slice per clock, so a single narrow carry chain replaces the full-width carry chain.
- Supports add and subtract with a borrow/carry flag and a start/done handshake.
- Optionally performs modular correction against a supplied modulus, for field add/sub in the point-arithmetic sequencer.

Parameters:
- WIDTH, 384, operand width in bits; must be a multiple of LIMB.
- LIMB, 64, bits processed per cycle; NLIMB = WIDTH/LIMB limbs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- subtract  input  1  0 = A+B, 1 = A-B; sampled with start.
- in_a  input  WIDTH  operand A; sampled with start.
- in_b  input  WIDTH  operand B; sampled with start.
- in_m  input  WIDTH  modulus M; sampled with start; ignored unless MODADD_EN is defined.
- result  output  WIDTH+1  sum/difference; bit WIDTH is the carry (add) or borrow (sub).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid from this cycle.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, limb counter 0, result 0, busy 0, done 0, internal carry 0.
  - Assertion mid-operation aborts immediately.
  - No done is produced for the aborted request.
- IDLE:
  - On start=1, latch in_a, in_b, in_m and subtract.
  - Set carry = subtract, limb index = 0, go to ADD, busy=1.
- ADD: each edge processes limb i:
  - {c, s_i} = A_i + (subtract ? ~B_i : B_i) + c.
  - s_i is written to T[i*LIMB +: LIMB]; i increments.
  - After limb NLIMB-1: T[WIDTH] = c XOR subtract, so it is the carry-out for add and the borrow (1 when A<B) for sub.
  - Without MODADD_EN: go to DONE.
- DONE (one cycle):
  - result <= T, done=1, busy=0.
  - Next state IDLE; a new start is accepted in the following cycle.
- Latency: done is high exactly NLIMB+1 cycles after the edge at which start was sampled (7 for default parameters).
- Arithmetic is modulo 2^WIDTH with the extra flag bit.
  - Subtract uses two's complement via carry-in 1, never a separate negate.
  - Subtracting B=0 gives flag 0.
- start while busy/DONE: ignored, with no queuing. Input changes after acceptance have no effect.
- result holds its last value until the next DONE; it is not cleared by a new start.
- done never asserts twice per accepted start.

Optional Feature:
- Macro: MODADD_EN.
- Defined: after ADD, the block enters CORR for NLIMB further cycles, limb-serially computing U:
  - U = T - M for add.
  - U = T + M for sub.
- Final selection:
  - add: result = U if T[WIDTH]=1 or T[WIDTH-1:0] >= M (no borrow in U); else T.
  - sub: result = U if T[WIDTH]=1 (borrow); else T.
  - result[WIDTH] is always 0.
- Latency is fixed at 2*NLIMB+1 regardless of whether correction is applied.
- Defined or not, inputs must satisfy A, B < M; behaviour for out-of-range inputs is the raw arithmetic above, with no error flag.
- Undefined: in_m is ignored, there is no CORR state, and latency is NLIMB+1.

Test Plan:
- Add: A=2^384-1, B=1 -> done at cycle 7, result = 0x1_000...0 (bit 384 set, low bits 0).
- Sub: A=5, B=7 -> result[383:0] = 2^384-2, result[384]=1; and A=7, B=5 -> result=2, flag 0.
- Back-to-back and interference: start held high continuously.
  - Two completions spaced 8 cycles apart, one done pulse each.
  - Toggling in_a mid-operation does not change the result.
- Reset mid-operation: assert reset at cycle 3 of an add.
  - done stays 0; result=0; busy=0 immediately.
  - Next start completes normally in 7 cycles.
- Carry across limbs: A=0x0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, B=1 -> result=0x2_0000_0000_0000_0000, flag 0.
- MODADD_EN, P-256 prime p:
  - A=p-1, B=2 -> result=1 at cycle 13.
  - sub A=1, B=2 -> result=p-1.
  - A=3, B=4 -> result=7 (no correction applied).
